aq_axi_cmd_arbiter: RTL
=======================

# aq_axi_cmd_arbiter

- Shares the local command interface of the team's AXI burst master between `NUM_REQ` requesters.
- Runs independent round-robin arbitration for the write channel and for the read channel, then sequences each granted command as start → busy → done.
- Produces one-hot owner selects so external FIFO muxes can be steered, and routes the master's completion back to the owning requester.
- Sits between DMA clients (camera/feature-extraction engines) and the AXI master.

## Interface

Parameters:
- `NUM_REQ`, 4: requesters per channel (2–8).
- `IDX_W`, 2: owner index width, equal to clog2(`NUM_REQ`).

Ports (x = WR or RD, one set per channel):
- `ACLK` in 1: single clock.
- `ARESETN` in 1: reset, asynchronous and active-low.
- `x_REQ` in `NUM_REQ`: per-requester request level.
- `x_REQ_ADRS` in 32*`NUM_REQ`: byte address; requester i uses bits [32i+31:32i].
- `x_REQ_LEN` in 32*`NUM_REQ`: byte length; requester i uses bits [32i+31:32i].
- `x_GNT` out `NUM_REQ`: one-cycle pulse when the command is accepted.
- `x_REQ_DONE` out `NUM_REQ`: one-cycle completion pulse to the owner.
- `x_ZLEN_ERR` out 1: pulse, rejected zero-length command.
- `x_SEL` out `NUM_REQ`: one-hot owner, held from START through CMPL.
- `x_OWNER` out `IDX_W`: binary owner index.
- `x_BUSY` out 1: channel is not IDLE.
- `MST_x_START` out 1: start pulse to the master.
- `MST_x_ADRS` out 32: command address to the master.
- `MST_x_LEN` out 32: command length to the master.
- `MST_x_READY` in 1: master is idle.
- `MST_x_DONE` in 1: master completion pulse.

## Operation

- Each channel is an identical FSM with states IDLE, START, BUSY, CMPL. The two channels never interact.
- **IDLE**
  - Waits for `x_REQ` != 0 and `MST_x_READY`=1.
  - Winner is the lowest index at or after `rr_ptr`, modulo `NUM_REQ`.
  - Latches the winner's ADRS/LEN and owner.
  - If LEN != 0: go to START.
  - If LEN == 0: go to CMPL and mark a zero-length command.
- **START** (one cycle)
  - `MST_x_START`=1 and `x_GNT[owner]`=1; ADRS/LEN are driven from the latches.
  - Go to BUSY.
- **BUSY**
  - Waits for `MST_x_DONE`, then goes to CMPL.
  - `MST_x_READY` is ignored in this state.
- **CMPL** (one cycle)
  - `x_REQ_DONE[owner]`=1.
  - Zero-length case: `x_GNT[owner]`=1 and `x_ZLEN_ERR`=1 in the same cycle; the master is never started.
  - `rr_ptr` <= (owner+1) mod `NUM_REQ`; go to IDLE.
- **Request rules**
  - A requester holds REQ, ADRS and LEN stable until its GNT.
  - REQ withdrawn before grant is legal and is simply not considered.
  - REQ still high in the cycle after DONE counts as a new request.
- `MST_x_ADRS`/`MST_x_LEN` hold their last latched value outside START; they are meaningful only while `MST_x_START`=1.
- Arithmetic: owner+1 wraps modulo `NUM_REQ`, including non-power-of-two values. LEN is passed through unmodified; the master performs the −1.
- `x_SEL` = 0 and `x_OWNER` = 0 in IDLE.

## Timing

- Reset value of every output is 0; `rr_ptr` = 0 and both FSMs are in IDLE.
- Reset mid-operation returns immediately to IDLE and produces no DONE pulse. The owning requester must be reset too.
- Request and ready both seen in cycle t:
  - START, GNT, SEL and OWNER valid in cycle t+1.
  - BUSY from t+2.
- `MST_x_DONE` in cycle d:
  - CMPL and `x_REQ_DONE` in d+1.
  - IDLE in d+2; the earliest next START is d+3.
- Zero-length request in cycle t: CMPL in t+1, with GNT, DONE and ZLEN_ERR all in t+1.
- `MST_x_DONE` arriving outside BUSY is ignored.
- Write and read channels may be in START in the same cycle.

## Configuration

- `AQ_ARB_PRIO_EN`
  - Defined: requester 0 is fixed highest priority. It wins whenever its REQ is high in IDLE; requesters 1..N−1 round-robin among themselves, and the pointer is not advanced when 0 wins.
  - Undefined: pure round-robin across all requesters as described above.

## Structure

- Package `aq_axi_arb_pkg` holds:
  - the state encoding (2-bit: IDLE=0, START=1, BUSY=2, CMPL=3);
  - `ADRS_W`=32 and `LEN_W`=32.
- Sub-module `aq_axi_arb_chan` contains the round-robin picker, latches and FSM for one channel, and is parameterised by `NUM_REQ`.
- The top level instantiates `aq_axi_arb_chan` twice (write, read) and contains wiring only.

## Test plan

- **Single write.** REQ[2]=1, ADRS=0x1000_0000, LEN=4096, READY=1 → next cycle START=1, GNT[2]=1, `MST_WR_ADRS`=0x1000_0000, `MST_WR_LEN`=4096, `WR_SEL`=0b0100. DONE injected 50 cycles later → `WR_REQ_DONE[2]` one cycle later.
- **Fairness.** All four REQ held for 8 commands → grant order 0,1,2,3,0,1,2,3. With `AQ_ARB_PRIO_EN` and REQ[0] held → every grant goes to 0.
- **Zero length.** REQ[1]=1, LEN=0 → GNT[1], REQ_DONE[1] and ZLEN_ERR in the same cycle; `MST_WR_START` never asserted; `rr_ptr` advances to 2.
- **Back-pressure and withdrawal.**
  - READY=0 with REQ[3] high for 20 cycles → no START.
  - REQ[3] dropped while READY=0, then READY=1 → no grant.
- **Concurrent channels and reset.**
  - WR and RD requests in the same cycle → both STARTs in the same cycle.
  - ARESETN pulsed low while both channels are BUSY → all outputs 0 immediately; no DONE afterwards.
  - Next request is granted to requester 0.

Source files
------------

// File: rtl/aq_axi_arb_pkg.sv
// rtl/aq_axi_arb_pkg.sv - shared types and widths for the AXI command arbiter
// Purpose: channel FSM state encoding and command field widths.
// Contents: arb_state_t (IDLE=0, START=1, BUSY=2, CMPL=3), ADRS_W, LEN_W.
package aq_axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CMPL  = 2'd3
    } arb_state_t;

    localparam int ADRS_W = 32;
    localparam int LEN_W  = 32;

endpackage

// File: rtl/aq_axi_cmd_arbiter_if.sv
// rtl/aq_axi_cmd_arbiter_if.sv - one channel's requester and master command bundle
// Purpose: groups the per-channel signals (requesters on one side, AXI master on the other).
// Modports: master = arbiter side (drives GNT/REQ_DONE/ZLEN_ERR/SEL/OWNER/BUSY/MST_*),
//           slave  = environment side (drives REQ/REQ_ADRS/REQ_LEN/MST_READY/MST_DONE).
interface aq_axi_cmd_arbiter_if
    import aq_axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]        REQ;
    logic [ADRS_W*NUM_REQ-1:0] REQ_ADRS;
    logic [LEN_W*NUM_REQ-1:0]  REQ_LEN;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        REQ_DONE;
    logic                      ZLEN_ERR;
    logic [NUM_REQ-1:0]        SEL;
    logic [IDX_W-1:0]          OWNER;
    logic                      BUSY;
    logic                      MST_START;
    logic [ADRS_W-1:0]         MST_ADRS;
    logic [LEN_W-1:0]          MST_LEN;
    logic                      MST_READY;
    logic                      MST_DONE;

    modport master (
        input  REQ, REQ_ADRS, REQ_LEN, MST_READY, MST_DONE,
        output GNT, REQ_DONE, ZLEN_ERR, SEL, OWNER, BUSY, MST_START, MST_ADRS, MST_LEN
    );

    modport slave (
        output REQ, REQ_ADRS, REQ_LEN, MST_READY, MST_DONE,
        input  GNT, REQ_DONE, ZLEN_ERR, SEL, OWNER, BUSY, MST_START, MST_ADRS, MST_LEN
    );
endinterface

// File: rtl/aq_axi_arb_chan.sv
// rtl/aq_axi_arb_chan.sv - round-robin picker, command latches and FSM for one channel
// Purpose: picks a requester, sequences IDLE -> START -> BUSY -> CMPL, rejects zero-length commands.
// Ports: ACLK/ARESETN; req/req_adrs/req_len from requesters; gnt/req_done/zlen_err/sel/owner/busy
//        back to them; mst_start/mst_adrs/mst_len/mst_ready/mst_done to the AXI master.
// Config: AQ_ARB_PRIO_EN gives requester 0 fixed top priority.
module aq_axi_arb_chan
    import aq_axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [ADRS_W*NUM_REQ-1:0] req_adrs,
    input  logic [LEN_W*NUM_REQ-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      zlen_err,
    output logic [NUM_REQ-1:0]        sel,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy,
    output logic                      mst_start,
    output logic [ADRS_W-1:0]         mst_adrs,
    output logic [LEN_W-1:0]          mst_len,
    input  logic                      mst_ready,
    input  logic                      mst_done
);

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ADRS_W-1:0]   pick_adrs;
    logic [LEN_W-1:0]    pick_len;

    // (a + b) mod NUM_REQ for a < NUM_REQ, b < NUM_REQ; correct for non-power-of-two counts
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan offsets from far to near so the nearest requester at/after rr_ptr is kept last
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
`ifdef AQ_ARB_PRIO_EN
        if (req[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
        pick_adrs = '0;
        pick_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_adrs = req_adrs[i*ADRS_W +: ADRS_W];
                pick_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
        pick_onehot = NUM_REQ'(1) << pick_idx;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            req_done  <= '0;
            zlen_err  <= 1'b0;
            sel       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            mst_start <= 1'b0;
            mst_adrs  <= '0;
            mst_len   <= '0;
        end else begin
            gnt       <= '0;
            req_done  <= '0;
            zlen_err  <= 1'b0;
            mst_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found && mst_ready) begin
                        owner    <= pick_idx;
                        sel      <= pick_onehot;
                        mst_adrs <= pick_adrs;
                        mst_len  <= pick_len;
                        busy     <= 1'b1;
                        gnt      <= pick_onehot;
                        if (pick_len != '0) begin
                            state     <= ST_START;
                            mst_start <= 1'b1;
                        end else begin
                            // Zero length: grant and complete together, master never started
                            state    <= ST_CMPL;
                            req_done <= pick_onehot;
                            zlen_err <= 1'b1;
                        end
                    end
                end
                ST_START: state <= ST_BUSY;
                ST_BUSY: begin
                    if (mst_done) begin
                        state    <= ST_CMPL;
                        req_done <= sel;
                    end
                end
                ST_CMPL: begin
                    state <= ST_IDLE;
                    sel   <= '0;
                    owner <= '0;
                    busy  <= 1'b0;
`ifdef AQ_ARB_PRIO_EN
                    if (owner != '0) rr_ptr <= wrap_add(owner, 1);
`else
                    rr_ptr <= wrap_add(owner, 1);
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/aq_axi_cmd_arbiter.sv
// rtl/aq_axi_cmd_arbiter.sv - shares the AXI burst master command port between NUM_REQ requesters
// Purpose: independent write and read arbiters; wiring only.
// Ports: ACLK, ARESETN (async, active-low); wr_if/rd_if channel bundles (master modport).
// Config: AQ_ARB_PRIO_EN (requester 0 fixed highest priority) is handled in aq_axi_arb_chan.
module aq_axi_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    aq_axi_cmd_arbiter_if.master wr_if,
    aq_axi_cmd_arbiter_if.master rd_if
);

    aq_axi_arb_chan #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_wr_chan (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (wr_if.REQ),
        .req_adrs  (wr_if.REQ_ADRS),
        .req_len   (wr_if.REQ_LEN),
        .gnt       (wr_if.GNT),
        .req_done  (wr_if.REQ_DONE),
        .zlen_err  (wr_if.ZLEN_ERR),
        .sel       (wr_if.SEL),
        .owner     (wr_if.OWNER),
        .busy      (wr_if.BUSY),
        .mst_start (wr_if.MST_START),
        .mst_adrs  (wr_if.MST_ADRS),
        .mst_len   (wr_if.MST_LEN),
        .mst_ready (wr_if.MST_READY),
        .mst_done  (wr_if.MST_DONE)
    );

    aq_axi_arb_chan #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rd_chan (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (rd_if.REQ),
        .req_adrs  (rd_if.REQ_ADRS),
        .req_len   (rd_if.REQ_LEN),
        .gnt       (rd_if.GNT),
        .req_done  (rd_if.REQ_DONE),
        .zlen_err  (rd_if.ZLEN_ERR),
        .sel       (rd_if.SEL),
        .owner     (rd_if.OWNER),
        .busy      (rd_if.BUSY),
        .mst_start (rd_if.MST_START),
        .mst_adrs  (rd_if.MST_ADRS),
        .mst_len   (rd_if.MST_LEN),
        .mst_ready (rd_if.MST_READY),
        .mst_done  (rd_if.MST_DONE)
    );

endmodule
